// File: rtl/bias_add_stage_if.sv
// Lane-parallel stream bundle between the adder tree, the bias stage and its consumer.
// The slave view is the bias stage; the master view is the surrounding datapath.
interface bias_add_stage_if #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned W            = 18
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [N_adder_tree*W-1:0] in_data;
  logic [N_adder_tree*W-1:0] bias;
  logic                      relu_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_adder_tree*W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, bias, relu_en, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, bias, relu_en, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bias_add_stage.sv
// Two-stage elastic bias adder: S1 holds exact W+1-bit lane sums, S2 holds saturated and
// optionally rectified lanes. Counts output beats in which any lane saturated.
module bias_add_stage #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned W            = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bias_add_stage_if.slave       bus,
  input  logic                  sat_clr,
  output logic [15:0]           sat_count
);

  logic                             s1_valid_q;
  logic                             s1_relu_q;
  logic [N_adder_tree-1:0][W:0]     s1_sum_q;
  logic [N_adder_tree-1:0][W:0]     s1_sum_d;
  logic                             s2_valid_q;
  logic [N_adder_tree-1:0][W-1:0]   s2_data_q;
  logic [N_adder_tree-1:0][W-1:0]   s2_data_d;
  logic [N_adder_tree-1:0]          lane_sat;
  logic                             any_sat;
  logic                             s2_adv;
  logic                             in_fire;
  logic [15:0]                      sat_count_q;

  // S2 advances whenever it is empty or its beat is being taken; S1 follows it.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_sum_d = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      s1_sum_d[i] = {bus.in_data[W*i+W-1], bus.in_data[W*i +: W]}
                  + {bus.bias[W*i+W-1], bus.bias[W*i +: W]};
    end
  end

  // Overflow of the W+1-bit sum shows as a mismatch between its top two bits.
  always_comb begin
    s2_data_d = '0;
    lane_sat  = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      lane_sat[i] = s1_sum_q[i][W] != s1_sum_q[i][W-1];
      if (!lane_sat[i]) begin
        s2_data_d[i] = s1_sum_q[i][W-1:0];
      end else if (!s1_sum_q[i][W]) begin
        s2_data_d[i] = {1'b0, {(W-1){1'b1}}};
      end else begin
        s2_data_d[i] = {1'b1, {(W-1){1'b0}}};
      end
      if (s1_relu_q && s2_data_d[i][W-1]) begin
        s2_data_d[i] = '0;
      end
    end
  end

  assign any_sat = |lane_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      sat_count_q <= '0;
    end else begin
      if (in_fire) begin
        s1_sum_q  <= s1_sum_d;
        s1_relu_q <= bus.relu_en;
      end
      if (in_fire) begin
        s1_valid_q <= 1'b1;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
        end
      end
      // Clear wins over a coincident increment; the counter sticks at all-ones.
      if (sat_clr) begin
        sat_count_q <= '0;
      end else if (s2_adv && s1_valid_q && any_sat && (sat_count_q != 16'hFFFF)) begin
        sat_count_q <= sat_count_q + 16'd1;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign sat_count     = sat_count_q;

endmodule
